mainmem_arbiter: RTL and testbench
==================================

MAINMEM_ARBITER -- requirements
Module: mainmem_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, width of address and data on both sides.
REQ-002 Parameter: LANES, default 2, number of memory slices, one lane-enable bit per slice.
REQ-003 Port: clk  input  1  single clock for the block, posedge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Ports per master n in {0,1}: mn_req  input  1  transaction request, held until ack.
REQ-006 Ports per master n: mn_wen  input  1  write when 1, read when 0.
REQ-007 Ports per master n: mn_addr  input  XLEN  byte address.
REQ-008 Ports per master n: mn_dat_i  input  XLEN  write data.
REQ-009 Ports per master n: mn_lane  input  LANES  slice enables.
REQ-010 Ports per master n: mn_ack  output  1  one-cycle completion pulse.
REQ-011 Ports per master n: mn_dat_o  output  XLEN  read data, valid only with mn_ack.
REQ-012 Port: s_req  output  1  memory request.
REQ-013 Port: s_wen  output  1  memory write enable.
REQ-014 Port: s_addr  output  XLEN  memory address.
REQ-015 Port: s_dat_o  output  XLEN  memory write data.
REQ-016 Port: s_lane  output  LANES  memory slice enables.
REQ-017 Port: s_dat_i  input  XLEN  memory read data; registered one cycle after s_req; zero when the memory was not enabled.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE and RESP, plus a 1-bit grant register gnt.
REQ-019 IDLE: if any mn_req=1, the block SHALL arbitrate, load gnt, and go to ISSUE next cycle; otherwise it SHALL stay in IDLE.
REQ-020 ISSUE: s_req=1; s_wen, s_addr, s_dat_o and s_lane SHALL equal the granted master's inputs combinationally; next state is RESP.
REQ-021 RESP: m<gnt>_ack=1 and m<gnt>_dat_o=s_dat_i for exactly one cycle; next state is IDLE.
REQ-022 Latency SHALL be exactly 2 cycles from the IDLE sampling edge to ack, for both reads and writes; each transaction SHALL occupy exactly 3 cycles.
REQ-023 In every state other than ISSUE, all s_* outputs SHALL be 0.
REQ-024 A non-granted master's ack and dat_o, and all acks and dat_o outside RESP, SHALL be 0.
REQ-025 Masters SHALL hold req/wen/addr/dat_i/lane stable from assertion until ack; the block SHALL NOT check this.
REQ-026 Req dropped before grant SHALL be ignored with no ack; req dropped after grant SHALL still complete with ack.
REQ-027 s_lane=0 with s_req=1 SHALL be passed through unchanged; ack still occurs, and read data is 0.
REQ-028 A master holding req through its ack cycle SHALL be treated as a new request at the next IDLE.

Reset
REQ-029 rst=0 SHALL force state IDLE, gnt=0, and all outputs 0 asynchronously, including mid-ISSUE or mid-RESP; the in-flight transaction SHALL be dropped with no ack.
REQ-030 The first arbitration SHALL occur at the first posedge after rst deasserts where a req is high.

Configuration
REQ-031 Macro MAINMEM_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests, the master not granted last wins, and the last-granted pointer resets to 1 so m0 wins the first tie.
REQ-032 Macro MAINMEM_ARB_RR_EN undefined: fixed priority; m0 always wins ties.

Verification
REQ-033 Read: preload word 0x10 = 0xDEADBEEF; m0 reads 0x10 with lane=2'b11 -> s_req high at cycle 1 only, m0_ack at cycle 2, m0_dat_o=0xDEADBEEF.
REQ-034 Write then read: m1 writes 0x12345678 to 0x20, lane=2'b01, over old 0xAAAAAAAA -> readback = 0xAAAA5678.
REQ-035 Simultaneous continuous requests, RR_EN defined -> acks alternate m0, m1, m0, m1, one ack every 3 cycles; RR_EN undefined -> only m0 acked.
REQ-036 Reset: assert rst=0 during ISSUE -> s_req=0 immediately, no ack; after release, the pending req completes normally.
REQ-037 Withdrawn request: m1_req pulses for 1 cycle while m0 is in RESP -> no m1_ack, s_req never driven for m1.

Source files
------------

// File: rtl/mainmem_arbiter.sv
// mainmem_arbiter: two-master arbiter in front of a single main-memory port.
// Each transaction is IDLE (arbitrate) -> ISSUE (drive memory) -> RESP (ack).
// Optional feature: define MAINMEM_ARB_RR_EN for round-robin tie breaking;
// the default build uses fixed priority with m0 winning ties.
module mainmem_arbiter #(
    parameter int XLEN  = 32,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_req,
    input  logic             m0_wen,
    input  logic [XLEN-1:0]  m0_addr,
    input  logic [XLEN-1:0]  m0_dat_i,
    input  logic [LANES-1:0] m0_lane,
    output logic             m0_ack,
    output logic [XLEN-1:0]  m0_dat_o,

    input  logic             m1_req,
    input  logic             m1_wen,
    input  logic [XLEN-1:0]  m1_addr,
    input  logic [XLEN-1:0]  m1_dat_i,
    input  logic [LANES-1:0] m1_lane,
    output logic             m1_ack,
    output logic [XLEN-1:0]  m1_dat_o,

    output logic             s_req,
    output logic             s_wen,
    output logic [XLEN-1:0]  s_addr,
    output logic [XLEN-1:0]  s_dat_o,
    output logic [LANES-1:0] s_lane,
    input  logic [XLEN-1:0]  s_dat_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   gnt;
    logic   pick;

`ifdef MAINMEM_ARB_RR_EN
    logic   last_gnt;

    // Round-robin choice: on a tie the master not granted last time wins.
    always_comb begin
        pick = 1'b0;
        if (m0_req && m1_req)
            pick = ~last_gnt;
        else
            pick = m1_req;
    end
`else
    // Fixed priority choice: m0 wins whenever it is requesting.
    always_comb begin
        pick = m1_req && !m0_req;
    end
`endif

    // Transaction sequencer; acks are registered so they are a clean one-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            gnt    <= 1'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
`ifdef MAINMEM_ARB_RR_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt   <= pick;
`ifdef MAINMEM_ARB_RR_EN
                        last_gnt <= pick;
`endif
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Grant is committed here; a request dropped now still completes.
                    m0_ack <= ~gnt;
                    m1_ack <= gnt;
                    state  <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory side follows the granted master only while in ISSUE, zero otherwise.
    always_comb begin
        s_req   = 1'b0;
        s_wen   = 1'b0;
        s_addr  = '0;
        s_dat_o = '0;
        s_lane  = '0;
        if (state == ISSUE) begin
            s_req   = 1'b1;
            s_wen   = gnt ? m1_wen   : m0_wen;
            s_addr  = gnt ? m1_addr  : m0_addr;
            s_dat_o = gnt ? m1_dat_i : m0_dat_i;
            s_lane  = gnt ? m1_lane  : m0_lane;
        end
    end

    // Read data is forwarded only to the master being acknowledged.
    always_comb begin
        m0_dat_o = m0_ack ? s_dat_i : '0;
        m1_dat_o = m1_ack ? s_dat_i : '0;
    end

endmodule

// File: tb/tb_mainmem_arbiter.sv
// Self-checking bench for mainmem_arbiter with a behavioural two-slice memory.
module tb_mainmem_arbiter;

    localparam int XLEN  = 32;
    localparam int LANES = 2;

    logic             clk;
    logic             rst;
    logic             m0_req, m0_wen, m1_req, m1_wen;
    logic [XLEN-1:0]  m0_addr, m0_dat_i, m1_addr, m1_dat_i;
    logic [LANES-1:0] m0_lane, m1_lane;
    logic             m0_ack, m1_ack;
    logic [XLEN-1:0]  m0_dat_o, m1_dat_o;
    logic             s_req, s_wen;
    logic [XLEN-1:0]  s_addr, s_dat_o, s_dat_i;
    logic [LANES-1:0] s_lane;

    int errors = 0;
    int checks = 0;

    mainmem_arbiter #(.XLEN(XLEN), .LANES(LANES)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_dat_i(m0_dat_i),
        .m0_lane(m0_lane), .m0_ack(m0_ack), .m0_dat_o(m0_dat_o),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_dat_i(m1_dat_i),
        .m1_lane(m1_lane), .m1_ack(m1_ack), .m1_dat_o(m1_dat_o),
        .s_req(s_req), .s_wen(s_wen), .s_addr(s_addr), .s_dat_o(s_dat_o),
        .s_lane(s_lane), .s_dat_i(s_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 16 words, two 16-bit slices, read data registered one cycle.
    logic [31:0] mem [0:15] = '{4: 32'hDEADBEEF, 8: 32'hAAAAAAAA, default: 32'h0};
    logic [31:0] rd;
    always @(posedge clk) begin
        rd = '0;
        if (s_req) begin
            for (int l = 0; l < LANES; l++) begin
                if (s_lane[l]) begin
                    if (s_wen) mem[s_addr[5:2]][l*16 +: 16] <= s_dat_o[l*16 +: 16];
                    else       rd[l*16 +: 16] = mem[s_addr[5:2]][l*16 +: 16];
                end
            end
        end
        s_dat_i <= (s_req && !s_wen) ? rd : 32'h0;
    end

    typedef struct {
        bit          m;
        bit          chk;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          m;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] dat;
        logic [1:0]  lane;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input bit m, input bit chk, input logic [31:0] dat);
        exp_t e;
        e.m = m; e.chk = chk; e.dat = dat;
        sb.push_back(e);
    endtask

    task automatic drive(input bit m, input bit req, input bit wen, input logic [31:0] addr,
                         input logic [31:0] dat, input logic [1:0] lane);
        if (m == 1'b0) begin
            m0_req = req; m0_wen = wen; m0_addr = addr; m0_dat_i = dat; m0_lane = lane;
        end else begin
            m1_req = req; m1_wen = wen; m1_addr = addr; m1_dat_i = dat; m1_lane = lane;
        end
    endtask

    // Scoreboard: every ack must match the oldest expected completion.
    always @(negedge clk) begin
        if (m0_ack || m1_ack) begin
            checks++;
            if (m0_ack && m1_ack) begin
                errors++;
                $display("FAIL dual_ack: m0_ack=%0b m1_ack=%0b expected one", m0_ack, m1_ack);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_ack: m0_ack=%0b m1_ack=%0b expected none", m0_ack, m1_ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_master", {31'd0, m1_ack}, {31'd0, e.m});
                check("idle_dat_o", m1_ack ? m0_dat_o : m1_dat_o, 32'h0);
                if (e.chk) check("rd_data", m1_ack ? m1_dat_o : m0_dat_o, e.dat);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v.m, 1'b1, v.wen, v.addr, v.dat, v.lane);
        push(v.m, !v.wen, v.exp);
        @(posedge clk); #1;
        check("issue_s_req",  {31'd0, s_req}, 32'd1);
        check("issue_s_wen",  {31'd0, s_wen}, {31'd0, v.wen});
        check("issue_s_addr", s_addr, v.addr);
        check("issue_s_dat",  s_dat_o, v.dat);
        check("issue_s_lane", {30'd0, s_lane}, {30'd0, v.lane});
        @(posedge clk); #1;
        check("resp_ack", {30'd0, m1_ack, m0_ack}, v.m ? 32'd2 : 32'd1);
        check("resp_s_req", {31'd0, s_req}, 32'd0);
        drive(v.m, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        @(posedge clk); #1;
        check("idle_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    endtask

    initial begin
        vt[0] = '{m:0, wen:0, addr:32'h10, dat:32'h0,        lane:2'b11, exp:32'hDEADBEEF};
        vt[1] = '{m:1, wen:1, addr:32'h20, dat:32'h12345678, lane:2'b01, exp:32'h0};
        vt[2] = '{m:0, wen:0, addr:32'h20, dat:32'h0,        lane:2'b11, exp:32'hAAAA5678};
        vt[3] = '{m:1, wen:0, addr:32'h20, dat:32'h0,        lane:2'b10, exp:32'hAAAA0000};
        vt[4] = '{m:0, wen:1, addr:32'h30, dat:32'hCAFEF00D, lane:2'b10, exp:32'h0};
        vt[5] = '{m:1, wen:0, addr:32'h30, dat:32'h0,        lane:2'b11, exp:32'hCAFE0000};
        vt[6] = '{m:0, wen:0, addr:32'h10, dat:32'h0,        lane:2'b00, exp:32'h0};
        vt[7] = '{m:1, wen:1, addr:32'h10, dat:32'hFFFFFFFF, lane:2'b00, exp:32'h0};
        vt[8] = '{m:0, wen:0, addr:32'h10, dat:32'h0,        lane:2'b01, exp:32'h0000BEEF};

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        #1;
        check("rst_s_req",  {31'd0, s_req}, 32'd0);
        check("rst_s_addr", s_addr, 32'h0);
        check("rst_acks",   {30'd0, m1_ack, m0_ack}, 32'd0);
        check("rst_dat_o",  m0_dat_o | m1_dat_o, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        // Both masters request continuously from a fresh reset.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
`ifdef MAINMEM_ARB_RR_EN
        push(1'b0, 1'b1, 32'hDEADBEEF); push(1'b1, 1'b1, 32'hAAAA5678);
        push(1'b0, 1'b1, 32'hDEADBEEF); push(1'b1, 1'b1, 32'hAAAA5678);
`else
        for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 32'hDEADBEEF);
`endif
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b11);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 2'b11);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("cont_ack_cadence", {31'd0, m0_ack | m1_ack}, {31'd0, (k % 3) == 1});
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        repeat (2) @(posedge clk);

        // Reset asserted in the middle of ISSUE drops the transaction.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 2'b11);
        @(posedge clk); #1;
        check("pre_rst_s_req", {31'd0, s_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_s_req",  {31'd0, s_req}, 32'd0);
        check("mid_rst_s_addr", s_addr, 32'h0);
        @(posedge clk); #1;
        check("mid_rst_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        push(1'b0, 1'b1, 32'hCAFE0000);
        @(posedge clk); #1;
        check("post_rst_s_req", {31'd0, s_req}, 32'd1);
        @(posedge clk); #1;
        check("post_rst_ack", {30'd0, m1_ack, m0_ack}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        @(posedge clk);

        // m1 request withdrawn after one cycle during m0's RESP.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b01);
        push(1'b0, 1'b1, 32'h00005678);
        @(posedge clk); #1;
        check("wd_issue_addr", s_addr, 32'h20);
        @(posedge clk); #1;
        check("wd_m0_ack", {31'd0, m0_ack}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b11);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            check("wd_no_s_req", {31'd0, s_req}, 32'd0);
            check("wd_no_m1_ack", {31'd0, m1_ack}, 32'd0);
            @(posedge clk); #1;
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
